// File: rtl/debug_capture_if.sv
// debug_capture_if: capture FIFO output stream
// master drives head entry and valid, slave returns ready
interface debug_capture_if #(
  parameter int OUT_W = 8
);
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/debug_capture.sv
// debug_capture: masked probe change capture into a FWFT FIFO
// DEBUGGER_TIMESTAMP_EN prepends a TS_W timestamp to each entry
module debug_capture #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int TS_W         = 16,
  parameter bit STOP_ON_FULL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             stop,
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] data,
  output logic             trigger,
  debug_capture_if.master  tx,
  output logic [1:0]       state,
  output logic             overflow,
  output logic [15:0]      dropped
);
  localparam int AW = $clog2(DEPTH);
`ifdef DEBUGGER_TIMESTAMP_EN
  localparam int OUT_W = TS_W + WIDTH;
`else
  localparam int OUT_W = WIDTH;
`endif
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (TS_W < 1) begin : g_bad_ts
    $error("TS_W must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    RUN   = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q;
  logic             trig_q;
  logic             ovf_q;
  logic [15:0]      drop_q;
  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count_q, count_d;
  logic             change, full, push_req;
  logic             push, pop, arming;
  logic [OUT_W-1:0] entry;

`ifdef DEBUGGER_TIMESTAMP_EN
  logic [TS_W-1:0]  ts_q;

  // free-running stamp, restarts at the start of a session
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      ts_q <= '0;
    else if (arming) ts_q <= '0;
    else             ts_q <= ts_q + 1'b1;
  end

  assign entry = {ts_q, w};
`else
  assign entry = w;
`endif

  assign change   = |((w ^ prev_q) & mask);
  assign full     = (count_q == FULL_C);
  assign push_req = change &&
                    (state_q == ARMED || state_q == RUN);
  assign push     = push_req && !full;
  assign pop      = (count_q != '0) && tx.out_ready;
  assign count_d  = count_q
                  + {{AW{1'b0}}, push}
                  - {{AW{1'b0}}, pop};

  // next state; stop wins over arm, arm ignored in RUN
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!stop && arm) state_d = ARMED;
      ARMED: begin
        if (stop)        state_d = IDLE;
        else if (change) state_d = RUN;
      end
      RUN: begin
        if (stop) state_d = IDLE;
        else if (STOP_ON_FULL && count_d == FULL_C)
          state_d = DONE;
      end
      DONE: begin
        if (stop)     state_d = IDLE;
        else if (arm) state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase
  end

  assign arming = (state_d == ARMED) && (state_q != ARMED);

  // probe history, trigger pulse and session state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q  <= '0;
      trig_q  <= 1'b0;
      state_q <= IDLE;
    end else begin
      prev_q  <= w;
      trig_q  <= change;
      state_q <= state_d;
    end
  end

  // overflow accounting, cleared at session start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (arming) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (push_req && full) begin
      ovf_q <= 1'b1;
      if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_d;
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  assign data         = w;
  assign trigger      = trig_q;
  assign state        = state_q;
  assign overflow     = ovf_q;
  assign dropped      = drop_q;
  assign tx.out_data  = mem[rd_ptr];
  assign tx.out_valid = (count_q != '0);
endmodule

// File: tb/tb_debug_capture.sv
// tb_debug_capture: directed table plus corner sequences
// two DEPTH=4 instances: drop-and-count and stop-on-full
module tb_debug_capture;
  localparam int W   = 8;
  localparam int D   = 4;
  localparam int TSW = 4;
`ifdef DEBUGGER_TIMESTAMP_EN
  localparam int OW = TSW + W;
`else
  localparam int OW = W;
`endif

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         arm   = 1'b0;
  logic         stop  = 1'b0;
  logic         rdy   = 1'b0;
  logic [W-1:0] w     = '0;
  logic [W-1:0] mask  = '1;

  logic [W-1:0] data0, data1;
  logic         trig0, trig1;
  logic [1:0]   st0, st1;
  logic         ov0, ov1;
  logic [15:0]  dr0, dr1;

  debug_capture_if #(.OUT_W(OW)) if0 ();
  debug_capture_if #(.OUT_W(OW)) if1 ();
  assign if0.out_ready = rdy;
  assign if1.out_ready = rdy;

  debug_capture #(
    .WIDTH(W), .DEPTH(D), .TS_W(TSW),
    .STOP_ON_FULL(1'b0)
  ) u0 (
    .clk(clk), .reset(reset), .arm(arm),
    .stop(stop), .w(w), .mask(mask),
    .data(data0), .trigger(trig0), .tx(if0),
    .state(st0), .overflow(ov0), .dropped(dr0)
  );

  debug_capture #(
    .WIDTH(W), .DEPTH(D), .TS_W(TSW),
    .STOP_ON_FULL(1'b1)
  ) u1 (
    .clk(clk), .reset(reset), .arm(arm),
    .stop(stop), .w(w), .mask(mask),
    .data(data1), .trigger(trig1), .tx(if1),
    .state(st1), .overflow(ov1), .dropped(dr1)
  );

  always #5 clk = ~clk;

  int pass_n  = 0;
  int total_n = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         arm;
    logic         stop;
    logic         rdy;
    logic [W-1:0] w;
    logic [W-1:0] mask;
    logic         trig;
    logic         vld;
    logic [W-1:0] dat;
    logic [1:0]   st;
  } vec_t;

  vec_t tv [11];

  initial begin
    // arm stop rdy w mask | trig vld dat st
    tv[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 2'b01};
    tv[1]  = '{1'b0, 1'b0, 1'b0, 8'h5A, 8'hFF, 1'b1, 1'b1, 8'h5A, 2'b10};
    tv[2]  = '{1'b0, 1'b0, 1'b1, 8'h5A, 8'hFF, 1'b0, 1'b0, 8'h00, 2'b10};
    tv[3]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 8'hFF, 1'b1, 1'b1, 8'hA5, 2'b10};
    tv[4]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 8'hFF, 1'b0, 1'b0, 8'h00, 2'b10};
    tv[5]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 8'hFF, 1'b0, 1'b0, 8'h00, 2'b00};
    tv[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00};
    tv[7]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h0F, 1'b0, 1'b0, 8'h00, 2'b01};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 8'hF0, 8'h0F, 1'b0, 1'b0, 8'h00, 2'b01};
    tv[9]  = '{1'b0, 1'b0, 1'b1, 8'hF3, 8'h0F, 1'b1, 1'b1, 8'hF3, 2'b10};
    tv[10] = '{1'b0, 1'b0, 1'b1, 8'hF3, 8'h0F, 1'b0, 1'b0, 8'h00, 2'b10};

    // reset state
    tick;
    tick;
    chk("rst_state", st0, 2'b00);
    chk("rst_valid", if0.out_valid, 1'b0);
    chk("rst_trig", trig0, 1'b0);
    chk("rst_ovf", ov0, 1'b0);
    chk("rst_drop", dr0, 16'd0);
    reset = 1'b1;
    tick;

    // basic capture and masking table
    for (int i = 0; i < 11; i++) begin
      arm  = tv[i].arm;
      stop = tv[i].stop;
      rdy  = tv[i].rdy;
      w    = tv[i].w;
      mask = tv[i].mask;
      tick;
      arm  = 1'b0;
      stop = 1'b0;
      chk($sformatf("v%0d_trig", i), trig0, tv[i].trig);
      chk($sformatf("v%0d_vld", i), if0.out_valid, tv[i].vld);
      chk($sformatf("v%0d_st", i), st0, tv[i].st);
      if (tv[i].vld)
        chk($sformatf("v%0d_dat", i),
            if0.out_data[W-1:0], tv[i].dat);
    end

    // reset mid-capture with three entries queued
    mask = 8'hFF;
    rdy  = 1'b0;
    stop = 1'b1;
    tick;
    stop = 1'b0;
    arm  = 1'b1;
    tick;
    arm  = 1'b0;
    w = 8'h11;
    tick;
    w = 8'h22;
    tick;
    w = 8'h33;
    tick;
    chk("mid_valid_pre", if0.out_valid, 1'b1);
    chk("mid_trig_pre", trig0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_async_state", st0, 2'b00);
    chk("mid_async_valid", if0.out_valid, 1'b0);
    chk("mid_async_trig", trig0, 1'b0);
    tick;
    chk("mid_state", st0, 2'b00);
    chk("mid_valid", if0.out_valid, 1'b0);
    chk("mid_drop", dr0, 16'd0);
    chk("mid_trig", trig0, 1'b0);
    w = 8'h00;
    reset = 1'b1;
    tick;

    // overflow and stop-on-full, six changes, no drain
    arm = 1'b1;
    tick;
    arm = 1'b0;
    chk("ovf_armed0", st0, 2'b01);
    chk("ovf_armed1", st1, 2'b01);
    for (int k = 1; k <= 6; k++) begin
      w = W'(k);
      tick;
      if (k == 4) chk("sof_done4", st1, 2'b11);
    end
    chk("ovf_state0", st0, 2'b10);
    chk("ovf_flag0", ov0, 1'b1);
    chk("ovf_drop0", dr0, 16'd2);
    chk("sof_state1", st1, 2'b11);
    chk("sof_flag1", ov1, 1'b0);
    chk("sof_drop1", dr1, 16'd0);

    // stop with arm together wins, then re-arm
    stop = 1'b1;
    arm  = 1'b1;
    tick;
    stop = 1'b0;
    arm  = 1'b0;
    chk("sof_stoparm1", st1, 2'b00);
    chk("ovf_stoparm0", st0, 2'b00);
    arm = 1'b1;
    tick;
    arm = 1'b0;
    chk("rearm_state0", st0, 2'b01);
    chk("rearm_ovf0", ov0, 1'b0);
    chk("rearm_drop0", dr0, 16'd0);
    chk("rearm_valid0", if0.out_valid, 1'b1);

    // queued entries drain in order across the re-arm
    rdy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("drain0_%0d", k),
          if0.out_data[W-1:0], W'(k));
      chk($sformatf("drain1_%0d", k),
          if1.out_data[W-1:0], W'(k));
      tick;
    end
    chk("drain0_empty", if0.out_valid, 1'b0);
    chk("drain1_empty", if1.out_valid, 1'b0);

`ifdef DEBUGGER_TIMESTAMP_EN
    // stamps at session cycles 3, 10 and 17 (wraps to 1)
    stop = 1'b1;
    tick;
    stop = 1'b0;
    arm  = 1'b1;
    tick;
    arm  = 1'b0;
    for (int c = 0; c < 3; c++) tick;
    w = 8'h77;
    tick;
    chk("ts_3", if0.out_data, {4'd3, 8'h77});
    for (int c = 4; c < 10; c++) tick;
    w = 8'h88;
    tick;
    chk("ts_10", if0.out_data, {4'd10, 8'h88});
    for (int c = 11; c < 17; c++) tick;
    w = 8'h99;
    tick;
    chk("ts_17", if0.out_data, {4'd1, 8'h99});
    chk("ts_17_u1", if1.out_data, {4'd1, 8'h99});
`endif

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
